// File: rtl/hazard_controller.sv
// hazard_controller
//   Hazard unit for a five-stage pipeline. It chooses the forwarding paths into
//   Execute and into the Decode branch comparator. It detects load-use and
//   branch-operand hazards, and it stalls the whole pipeline while a
//   data-memory access is outstanding. If the memory never answers, the block
//   latches a sticky timeout error and keeps the pipeline frozen until reset.
//
// Ports
//   i_CLK, i_RST                   clock (rising edge), async active-low reset
//   i_RsD, i_RtD                   Decode source registers
//   i_RsE, i_RtE                   Execute source registers
//   i_WriteRegE/M/W                destination register per stage
//   i_RegWriteE/M/W                register-write enable per stage
//   i_MemtoRegE/M                  result select, 2'b01 marks a load
//   i_BranchD                      branch in Decode
//   i_MemReqM, i_MemReadyM         data-memory request / completion
//   o_StallF/D/E/M, o_FlushE       pipeline register hold / D-E clear
//   o_ForwardAE/BE                 00 regfile, 01 Writeback, 10 Memory
//   o_ForwardAD/BD                 Decode comparator operand from Memory
//   o_MemTimeout                   sticky memory-timeout error
//   o_StallCycles                  saturating count of stalled cycles
module hazard_controller #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH     = 16,
  parameter int TIMEOUT       = 64
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic [1:0]               i_MemtoRegE,
  input  logic [1:0]               i_MemtoRegM,
  input  logic                     i_BranchD,
  input  logic                     i_MemReqM,
  input  logic                     i_MemReadyM,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_StallE,
  output logic                     o_StallM,
  output logic                     o_FlushE,
  output logic [1:0]               o_ForwardAE,
  output logic [1:0]               o_ForwardBE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic                     o_MemTimeout,
  output logic [CNT_WIDTH-1:0]     o_StallCycles
);

  // The wait counter only has to reach TIMEOUT-1 before the FSM leaves MEM_WAIT.
  localparam int WAIT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  wait_expired;
  logic                  lwstall;
  logic                  brstall;
  logic                  memstall;
  logic                  any_stall;

  // Forwarding selection. A match in Memory wins over a match in Writeback
  // because Memory holds the younger result. Register 0 is never forwarded.
  always_comb begin
    o_ForwardAE = 2'b00;
    o_ForwardBE = 2'b00;
    if ((i_RsE != '0) && (i_RsE == i_WriteRegM) && i_RegWriteM)
      o_ForwardAE = 2'b10;
    else if ((i_RsE != '0) && (i_RsE == i_WriteRegW) && i_RegWriteW)
      o_ForwardAE = 2'b01;
    if ((i_RtE != '0) && (i_RtE == i_WriteRegM) && i_RegWriteM)
      o_ForwardBE = 2'b10;
    else if ((i_RtE != '0) && (i_RtE == i_WriteRegW) && i_RegWriteW)
      o_ForwardBE = 2'b01;
    o_ForwardAD = (i_RsD != '0) && (i_RsD == i_WriteRegM) && i_RegWriteM;
    o_ForwardBD = (i_RtD != '0) && (i_RtD == i_WriteRegM) && i_RegWriteM;
  end

  // Hazards that the Memory-to-Decode forward cannot resolve: a load still in
  // Execute, or a branch whose operand is still being produced in Execute or
  // is being loaded in Memory.
  always_comb begin
    lwstall = (i_MemtoRegE == 2'b01) && ((i_RtE == i_RsD) || (i_RtE == i_RtD));
    brstall = i_BranchD &&
              ((i_RegWriteE && ((i_WriteRegE == i_RsD) || (i_WriteRegE == i_RtD))) ||
               ((i_MemtoRegM == 2'b01) &&
                ((i_WriteRegM == i_RsD) || (i_WriteRegM == i_RtD))));
  end

  assign wait_expired = (wait_cnt == WAIT_WIDTH'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST)
      state <= RUN;
    else
      state <= state_next;
  end

  // FSM next-state logic. A completion on the last allowed wait cycle still
  // counts as success. ERR has no exit other than reset.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (i_MemReqM && !i_MemReadyM) state_next = MEM_WAIT;
      MEM_WAIT: if (i_MemReadyM)               state_next = RUN;
                else if (wait_expired)         state_next = ERR;
      ERR:      state_next = ERR;
      default:  state_next = RUN;
    endcase
  end

  // Stall and flush outputs. In MEM_WAIT the cycle where the memory reports
  // ready is the cycle the access completes, so the pipeline is released on
  // that same cycle. A memory stall freezes every stage. It must not flush
  // Execute, because the instruction held there would be lost.
  always_comb begin
    o_StallF = 1'b0;
    o_StallD = 1'b0;
    o_StallE = 1'b0;
    o_StallM = 1'b0;
    o_FlushE = 1'b0;
    memstall = 1'b0;
    case (state)
      RUN:      memstall = i_MemReqM && !i_MemReadyM;
      MEM_WAIT: memstall = !i_MemReadyM;
      ERR:      memstall = 1'b1;
      default:  memstall = 1'b0;
    endcase
    if (memstall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_StallE = 1'b1;
      o_StallM = 1'b1;
    end else if (lwstall || brstall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_FlushE = 1'b1;
    end
  end

  assign any_stall = o_StallF || o_StallD || o_StallE || o_StallM;

  // Wait counter: it reads zero on the first MEM_WAIT cycle and rises by one
  // for each further cycle spent waiting.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST)
      wait_cnt <= '0;
    else if ((state == MEM_WAIT) && (state_next == MEM_WAIT))
      wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
    else
      wait_cnt <= '0;
  end

  // Sticky timeout flag and the saturating stall-cycle counter.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      o_MemTimeout  <= 1'b0;
      o_StallCycles <= '0;
    end else begin
      if (state_next == ERR)
        o_MemTimeout <= 1'b1;
      if (any_stall && (o_StallCycles != '1))
        o_StallCycles <= o_StallCycles + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter RF_ADDR_WIDTH, default 5, SHALL set the width of every register-file address port.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of o_StallCycles.
REQ-003 Parameter TIMEOUT, default 64, SHALL set the maximum memory-wait cycles before an error is raised.
REQ-004 The ports SHALL be as follows (name  direction  width  meaning):
- i_CLK  in  1  single clock, rising edge
- i_RST  in  1  asynchronous, active-low reset
- i_RsD, i_RtD  in  RF_ADDR_WIDTH  source registers of the instruction in Decode
- i_RsE, i_RtE  in  RF_ADDR_WIDTH  source registers of the instruction in Execute
- i_WriteRegE, i_WriteRegM, i_WriteRegW  in  RF_ADDR_WIDTH  destination register per stage
- i_RegWriteE, i_RegWriteM, i_RegWriteW  in  1  register-write enable per stage
- i_MemtoRegE, i_MemtoRegM  in  2  result select; 2'b01 = load
- i_BranchD  in  1  branch in Decode
- i_MemReqM  in  1  data-memory access in Memory stage
- i_MemReadyM  in  1  data memory completes the access this cycle
- o_StallF, o_StallD, o_StallE, o_StallM  out  1  hold the corresponding pipeline register
- o_FlushE  out  1  drives the clear input of the Decode/Execute register
- o_ForwardAE, o_ForwardBE  out  2  Execute operand select: 00 register file, 01 Writeback, 10 Memory
- o_ForwardAD, o_ForwardBD  out  1  Decode comparator operand taken from Memory
- o_MemTimeout  out  1  sticky memory-timeout error
- o_StallCycles  out  CNT_WIDTH  saturating count of stalled cycles

Function
REQ-005 o_ForwardAE SHALL be 10 when i_RsE!=0, i_RsE==i_WriteRegM and i_RegWriteM=1; otherwise 01 when i_RsE!=0, i_RsE==i_WriteRegW and i_RegWriteW=1; otherwise 00. o_ForwardBE SHALL follow the same rule using i_RtE.
REQ-006 o_ForwardAD SHALL be 1 when i_RsD!=0, i_RsD==i_WriteRegM and i_RegWriteM=1. o_ForwardBD SHALL follow the same rule using i_RtD.
REQ-007 Load-use stall (lwstall) SHALL be i_MemtoRegE==01 and (i_RtE==i_RsD or i_RtE==i_RtD).
REQ-008 Branch stall (brstall) SHALL be i_BranchD and either of:
- i_RegWriteE and i_WriteRegE matches i_RsD or i_RtD
- i_MemtoRegM==01 and i_WriteRegM matches i_RsD or i_RtD
REQ-009 All forwarding and stall outputs SHALL be combinational in the current cycle. The FSM state, o_MemTimeout and o_StallCycles SHALL be registered.
REQ-010 The FSM SHALL have three states: RUN, MEM_WAIT and ERR.
- RUN to MEM_WAIT when i_MemReqM=1 and i_MemReadyM=0
- MEM_WAIT to RUN when i_MemReadyM=1
- MEM_WAIT to ERR when i_MemReadyM=1 has not arrived within TIMEOUT consecutive MEM_WAIT cycles
- ERR exits only on reset
REQ-011 memstall SHALL be 1 in MEM_WAIT, in ERR, and in RUN when i_MemReqM=1 and i_MemReadyM=0.
REQ-012 When memstall=1: o_StallF, o_StallD, o_StallE and o_StallM SHALL all be 1, and o_FlushE SHALL be 0. memstall takes priority over lwstall and brstall.
REQ-013 When memstall=0 and (lwstall or brstall)=1: o_StallF=o_StallD=o_FlushE=1 and o_StallE=o_StallM=0.
REQ-014 When memstall, lwstall and brstall are all 0, every stall output and o_FlushE SHALL be 0.
REQ-015 The wait counter SHALL clear on entry to MEM_WAIT and increment on each MEM_WAIT cycle.
- i_MemReadyM=1 on the TIMEOUT-th wait cycle SHALL return the FSM to RUN, not ERR.
REQ-016 On entry to ERR, o_MemTimeout SHALL go to 1 and SHALL stay at 1 until reset.
REQ-017 o_StallCycles SHALL increment by 1 on each rising edge where any o_Stall* output was 1, and SHALL saturate at 2^CNT_WIDTH-1 without wrapping.

Reset
REQ-018 i_RST=0 SHALL immediately, without waiting for a clock edge:
- put the FSM in RUN
- clear the wait counter
- set o_MemTimeout=0 and o_StallCycles=0
REQ-019 Asserting reset during MEM_WAIT or ERR SHALL abandon the wait. After i_RST=1 the block SHALL resume from RUN on the next edge.

Verification
REQ-020 Forwarding: i_RsE=5, i_WriteRegM=5, i_RegWriteM=1, i_WriteRegW=5, i_RegWriteW=1 -> o_ForwardAE=10. With i_RsE=0 -> 00.
REQ-021 Load-use: i_MemtoRegE=01, i_RtE=3, i_RsD=3 -> o_StallF=o_StallD=o_FlushE=1, o_StallE=0. o_StallCycles increments by 1 per cycle held.
REQ-022 Memory wait: i_MemReqM=1, i_MemReadyM=0 for 5 cycles, then 1 -> all four stalls 1 for 5 cycles, o_FlushE=0, FSM back in RUN, o_StallCycles=5.
REQ-023 Timeout: TIMEOUT=4 with i_MemReadyM held at 0 -> ERR entered and o_MemTimeout=1, remaining 1 after i_MemReadyM=1. Reset pulse -> o_MemTimeout=0 and FSM in RUN.
REQ-024 Priority: lwstall=1 and memstall=1 in the same cycle -> o_FlushE=0 and o_StallE=1.
REQ-025 Saturation: CNT_WIDTH=4 with stall held for 20 cycles -> o_StallCycles=15.
